// File: rtl/wishbone_master_pkg.sv
// Shared types and width helpers for the Wishbone classic single-transfer master.
package wishbone_master_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  // Counter must hold 0..TIMEOUT; a zero-width vector is not legal, so floor at 1.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: cleared while idle, counts unanswered BUS cycles, flags the last allowed one.
module wb_timeout_counter
  import wishbone_master_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
      logic [CNT_W-1:0] cnt;

      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign expire = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/wishbone_master_fsm.sv
// Wishbone classic single-transfer master bridging a CPU strobe interface to the bus,
// with slave-error and timeout aborts reported back as one-cycle done/err pulses.
module wishbone_master_fsm
  import wishbone_master_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic              we_o,
  output logic              stb_o,
  output logic              cyc_o,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_dir,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err
);

  state_t state;
  logic   cnt_clr;
  logic   cnt_en;
  logic   expire;

  assign cnt_clr = (state == IDLE);
  assign cnt_en  = (state == BUS) && !ack_i && !err_i;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (expire)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      adr_o      <= '0;
      dat_o      <= '0;
      we_o       <= 1'b0;
      stb_o      <= 1'b0;
      cyc_o      <= 1'b0;
      cpu_data_o <= '0;
      cpu_busy   <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        IDLE: begin
          // A simultaneous read and write request resolves to the write.
          if (cpu_wr || cpu_rd) begin
            adr_o    <= cpu_dir;
            dat_o    <= cpu_data_i;
            we_o     <= cpu_wr;
            stb_o    <= 1'b1;
            cyc_o    <= 1'b1;
            cpu_busy <= 1'b1;
            state    <= BUS;
          end
        end
        BUS: begin
          if (err_i || ack_i || expire) begin
            we_o     <= 1'b0;
            stb_o    <= 1'b0;
            cyc_o    <= 1'b0;
            cpu_busy <= 1'b0;
            state    <= IDLE;
            // Error beats ack; ack on the final timeout edge still completes OK.
            if (err_i || !ack_i) begin
              cpu_err <= 1'b1;
            end else begin
              cpu_done <= 1'b1;
              if (!we_o) begin
                cpu_data_o <= dat_i;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
